// File: rtl/fft_dma_engine.sv
// Avalon-MM FFT accelerator: bursts NPTS samples from SDRAM, streams them through an
// external streaming FFT core, captures |X|^2 or Re{X} and writes the frame back.
module fft_dma_engine #(
  parameter int NPTS      = 512,
  parameter int FFT_W     = 16,
  parameter int ADDR_W    = 32,
  parameter int MAX_OUTST = 4,
  parameter int TIMEOUT   = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        slave_address,
  input  logic              slave_read,
  output logic [31:0]       slave_readdata,
  input  logic              slave_write,
  input  logic [31:0]       slave_writedata,
  output logic              slave_waitrequest,
  output logic [ADDR_W-1:0] master_address,
  output logic              master_read,
  input  logic [31:0]       master_readdata,
  input  logic              master_readdatavalid,
  output logic              master_write,
  output logic [31:0]       master_writedata,
  input  logic              master_waitrequest,
  output logic              fft_reset,
  output logic              fft_next,
  output logic [FFT_W-1:0]  fft_x,
  input  logic              fft_next_out,
  input  logic [FFT_W-1:0]  fft_y_re,
  input  logic [FFT_W-1:0]  fft_y_im,
  output logic              irq
);

  localparam int IW = $clog2(NPTS);
  localparam int CW = IW + 1;
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int MW = 2 * FFT_W;
  localparam int PW = 2 * FFT_W + 1;
  localparam int SW = (PW > 32) ? PW : 33;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_FEED, S_WAIT, S_CAPT, S_WRITE, S_DONE
  } state_t;

  state_t                   state_q;
  logic [CW-1:0]            issued_q, rcv_q;
  logic [OW-1:0]            outst_q;
  logic [IW-1:0]            idx_q;
  logic [TW-1:0]            tmo_q;
  logic [31:0]              src_q, dst_q, cycles_q, cyc_q;
  logic [ADDR_W-1:0]        maddr_q, dst_run_q;
  logic                     mode_q, done_q, err_q;
  logic                     mread_q, mwrite_q, fft_next_q, fft_reset_q;
  logic signed [FFT_W-1:0]  inbuf [NPTS];
  logic [31:0]              outbuf [NPTS];
  logic signed [FFT_W-1:0]  fft_x_q;
  logic [31:0]              wdata_q;

  logic                     acc, rdv, mread_d, start;
  logic [CW-1:0]            issued_d, rcv_d;
  logic [OW-1:0]            outst_d;
  logic [31:0]              cap_word;
  logic                     unused_rd;

  function automatic logic [PW-1:0] mag2(input logic signed [FFT_W-1:0] re,
                                         input logic signed [FFT_W-1:0] im);
    logic signed [MW-1:0] pr, pi;
    pr = MW'(re) * MW'(re);
    pi = MW'(im) * MW'(im);
    return {1'b0, pr} + {1'b0, pi};
  endfunction

  function automatic logic [31:0] sat32(input logic [PW-1:0] v);
    logic [SW-1:0] w;
    w = SW'(v);
    if (w > SW'(33'h0_FFFF_FFFF)) return 32'hFFFF_FFFF;
    return w[31:0];
  endfunction

  function automatic logic [31:0] sext32(input logic signed [FFT_W-1:0] v);
    return 32'(v);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // A pending read request is held until accepted; a new one is raised only while
  // words remain and a slot is free once this cycle's returns are accounted for.
  always_comb begin
    acc      = mread_q && !master_waitrequest;
    rdv      = (state_q == S_READ) && master_readdatavalid;
    issued_d = issued_q + CW'(acc);
    rcv_d    = rcv_q + CW'(rdv);
    outst_d  = outst_q + OW'(acc) - OW'(rdv);
    mread_d  = (mread_q && master_waitrequest) ||
               ((issued_d < CW'(NPTS)) && (outst_d < OW'(MAX_OUTST)));
    start    = slave_write && (slave_address == 3'd0) && slave_writedata[0] &&
               (state_q == S_IDLE);
    cap_word = mode_q ? sext32($signed(fft_y_re))
                      : sat32(mag2($signed(fft_y_re), $signed(fft_y_im)));
  end

  always_comb begin
    slave_readdata = '0;
    if (slave_read) begin
      case (slave_address)
        3'd1:    slave_readdata = {29'd0, err_q, done_q, state_q != S_IDLE};
        3'd2:    slave_readdata = src_q;
        3'd3:    slave_readdata = dst_q;
        3'd4:    slave_readdata = cycles_q;
        default: slave_readdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      issued_q    <= '0;
      rcv_q       <= '0;
      outst_q     <= '0;
      idx_q       <= '0;
      tmo_q       <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      cycles_q    <= '0;
      cyc_q       <= '0;
      maddr_q     <= '0;
      dst_run_q   <= '0;
      mode_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mread_q     <= 1'b0;
      mwrite_q    <= 1'b0;
      fft_next_q  <= 1'b0;
      fft_reset_q <= 1'b1;
    end else begin
      fft_next_q <= 1'b0;
      if (slave_write && slave_address == 3'd2) src_q <= {slave_writedata[31:2], 2'b00};
      if (slave_write && slave_address == 3'd3) dst_q <= {slave_writedata[31:2], 2'b00};
      if (slave_write && slave_address == 3'd1) begin
        if (slave_writedata[1]) done_q <= 1'b0;
        if (slave_writedata[2]) err_q  <= 1'b0;
      end
      if (state_q != S_IDLE) cyc_q <= sat_inc(cyc_q);

      case (state_q)
        S_IDLE: begin
          fft_reset_q <= 1'b1;
          if (start) begin
            state_q     <= S_READ;
            fft_reset_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mode_q      <= slave_writedata[1];
            maddr_q     <= ADDR_W'(src_q);
            dst_run_q   <= ADDR_W'(dst_q);
            issued_q    <= '0;
            rcv_q       <= '0;
            outst_q     <= '0;
            cyc_q       <= '0;
            mread_q     <= 1'b1;
          end
        end
        S_READ: begin
          issued_q <= issued_d;
          rcv_q    <= rcv_d;
          outst_q  <= outst_d;
          mread_q  <= mread_d;
          if (acc) maddr_q <= maddr_q + ADDR_W'(4);
          if (rcv_d == CW'(NPTS)) begin
            state_q    <= S_FEED;
            mread_q    <= 1'b0;
            fft_next_q <= 1'b1;
            idx_q      <= '0;
          end
        end
        S_FEED: begin
          idx_q <= idx_q + 1'b1;
          if (idx_q == IW'(NPTS - 1)) begin
            state_q <= S_WAIT;
            tmo_q   <= '0;
          end
        end
        // A frame start arriving on the timeout cycle still wins.
        S_WAIT: begin
          if (fft_next_out) begin
            state_q <= S_CAPT;
            idx_q   <= '0;
          end else if (tmo_q == TW'(TIMEOUT)) begin
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_CAPT: begin
          idx_q <= idx_q + 1'b1;
          if (idx_q == IW'(NPTS - 1)) begin
            state_q  <= S_WRITE;
            mwrite_q <= 1'b1;
            maddr_q  <= dst_run_q;
            idx_q    <= '0;
          end
        end
        S_WRITE: begin
          if (!master_waitrequest) begin
            if (idx_q == IW'(NPTS - 1)) begin
              mwrite_q <= 1'b0;
              state_q  <= S_DONE;
            end else begin
              idx_q   <= idx_q + 1'b1;
              maddr_q <= maddr_q + ADDR_W'(4);
            end
          end
        end
        S_DONE: begin
          if (!err_q) done_q <= 1'b1;
          cycles_q    <= sat_inc(cyc_q);
          fft_reset_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Sample and result storage carries no reset; control qualifies every use.
  always_ff @(posedge clk) begin
    if (state_q == S_READ && master_readdatavalid)
      inbuf[rcv_q[IW-1:0]] <= master_readdata[FFT_W-1:0];
    if (state_q == S_FEED) fft_x_q <= inbuf[idx_q];
    if (state_q == S_CAPT) outbuf[idx_q] <= cap_word;
    if (state_q == S_CAPT && idx_q == IW'(NPTS - 1))
      wdata_q <= outbuf[0];
    else if (state_q == S_WRITE && !master_waitrequest && idx_q != IW'(NPTS - 1))
      wdata_q <= outbuf[idx_q + 1'b1];
  end

  assign unused_rd         = ^master_readdata[31:FFT_W];
  assign slave_waitrequest = 1'b0;
  assign master_address    = maddr_q;
  assign master_read       = mread_q;
  assign master_write      = mwrite_q;
  assign master_writedata  = wdata_q;
  assign fft_reset         = fft_reset_q;
  assign fft_next          = fft_next_q;
  assign fft_x             = fft_x_q;
  assign irq               = done_q | err_q;

endmodule

// File: tb/tb_fft_dma_engine.sv
// Randomized bench for fft_dma_engine: SDRAM model with random stalls and latency,
// a DFT-computing FFT core model, and a reference for the written-back words.
module tb_fft_dma_engine;
  localparam int NPTS = 16, FFT_W = 16, ADDR_W = 32, MAX_OUTST = 4, TIMEOUT = 100;
  localparam logic [31:0] DST = 32'h2000, SRC_A = 32'h1000, SRC_B = 32'h3000;
  localparam real PI = 3.14159265358979;

  logic clk, rst_n;
  logic [2:0] slave_address;
  logic slave_read, slave_write, slave_waitrequest;
  logic [31:0] slave_readdata, slave_writedata;
  logic [ADDR_W-1:0] master_address;
  logic master_read, master_readdatavalid, master_write, master_waitrequest;
  logic [31:0] master_readdata, master_writedata;
  logic fft_reset, fft_next, fft_next_out, irq;
  logic [FFT_W-1:0] fft_x, fft_y_re, fft_y_im;

  fft_dma_engine #(.NPTS(NPTS), .FFT_W(FFT_W), .ADDR_W(ADDR_W), .MAX_OUTST(MAX_OUTST),
                   .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .slave_address(slave_address), .slave_read(slave_read),
    .slave_readdata(slave_readdata), .slave_write(slave_write),
    .slave_writedata(slave_writedata), .slave_waitrequest(slave_waitrequest),
    .master_address(master_address), .master_read(master_read),
    .master_readdata(master_readdata), .master_readdatavalid(master_readdatavalid),
    .master_write(master_write), .master_writedata(master_writedata),
    .master_waitrequest(master_waitrequest), .fft_reset(fft_reset), .fft_next(fft_next),
    .fft_x(fft_x), .fft_next_out(fft_next_out), .fft_y_re(fft_y_re), .fft_y_im(fft_y_im),
    .irq(irq));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory model: source image written by the stimulus, master traffic logged.
  typedef struct { int due; logic [31:0] data; } beat_t;
  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  logic [31:0] smem [0:4095];
  logic [31:0] rd_log [$];
  wr_t         wr_log [$];
  beat_t       rq [$];
  int cyc = 0, acc_tot = 0, ret_tot = 0, max_inflight = 0, overlap = 0, last_due = 0;
  bit wr_rand = 0;

  initial begin : mem_model
    master_waitrequest = 1'b0; master_readdatavalid = 1'b0; master_readdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      master_waitrequest = wr_rand ? 1'($urandom_range(0, 1)) : 1'b0;
      if (rst_n) begin
        if (master_read && !master_waitrequest) begin
          beat_t b;
          int lat;
          lat = wr_rand ? int'($urandom_range(1, 5)) : 1;
          b.due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
          b.data = smem[master_address[13:2]];
          last_due = b.due;
          rq.push_back(b);
          rd_log.push_back(master_address);
          acc_tot++;
        end
        if (master_write && !master_waitrequest) begin
          wr_t w;
          w.a = master_address; w.d = master_writedata;
          wr_log.push_back(w);
        end
        if (master_read && master_write) overlap++;
      end
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        master_readdatavalid = 1'b1;
        master_readdata = rq[0].data;
        void'(rq.pop_front());
        ret_tot++;
      end else begin
        master_readdatavalid = 1'b0;
        master_readdata = $urandom;
      end
      if (acc_tot - ret_tot > max_inflight) max_inflight = acc_tot - ret_tot;
    end
  end

  // FFT core model: 0 = true DFT, 1 = constant -32768 bins, 2 = never answers.
  int core_mode = 0, frames = 0, pulse_bad = 0;
  int xs [NPTS];
  int yre [NPTS];
  int yim [NPTS];

  initial begin : fft_model
    fft_next_out = 1'b0; fft_y_re = '0; fft_y_im = '0;
    forever begin
      @(negedge clk);
      if (rst_n && fft_next) begin
        for (int k = 0; k < NPTS; k++) begin
          @(negedge clk);
          if (fft_next) pulse_bad++;
          xs[k] = int'($signed(fft_x));
        end
        for (int k = 0; k < NPTS; k++) begin
          real sr, si;
          sr = 0.0; si = 0.0;
          for (int n = 0; n < NPTS; n++) begin
            sr += real'(xs[n]) * $cos(2.0 * PI * real'(n * k) / real'(NPTS));
            si -= real'(xs[n]) * $sin(2.0 * PI * real'(n * k) / real'(NPTS));
          end
          yre[k] = (core_mode == 1) ? -32768 : int'(sr);
          yim[k] = (core_mode == 1) ? -32768 : int'(si);
          if (yre[k] > 32767) yre[k] = 32767;
          if (yre[k] < -32768) yre[k] = -32768;
          if (yim[k] > 32767) yim[k] = 32767;
          if (yim[k] < -32768) yim[k] = -32768;
        end
        frames++;
        if (core_mode != 2) begin
          repeat (3) @(negedge clk);
          fft_next_out = 1'b1;
          for (int k = 0; k < NPTS; k++) begin
            @(negedge clk);
            fft_next_out = 1'b0;
            fft_y_re = 16'(yre[k]);
            fft_y_im = 16'(yim[k]);
          end
          @(negedge clk);
          fft_y_re = 16'($urandom); fft_y_im = 16'($urandom);
        end
      end
    end
  end

  function automatic logic [31:0] ref_word(input bit mode, input int re, input int im);
    longint m;
    if (mode) return 32'(re);
    m = longint'(re) * re + longint'(im) * im;
    if (m > 64'h0000_0000_FFFF_FFFF) return 32'hFFFF_FFFF;
    return 32'(m);
  endfunction

  task automatic reg_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    slave_address = a; slave_writedata = d; slave_write = 1'b1;
    @(negedge clk);
    slave_write = 1'b0;
  endtask

  task automatic reg_rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    slave_address = a; slave_read = 1'b1;
    #1 d = slave_readdata;
    slave_read = 1'b0;
  endtask

  task automatic wait_irq(input int budget);
    int n = 0;
    while (!irq && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("irq_wait", irq, 1'b1);
  endtask

  task automatic fill_src(input logic [31:0] base, input bit impulse);
    for (int k = 0; k < NPTS; k++)
      smem[base[13:2] + k] = impulse ? ((k == 0) ? 32'd1 : 32'd0) : $urandom;
  endtask

  int rd0, wr0, fr0;
  task automatic start_run(input logic [31:0] src, input bit mode, input int cm, input bit wr);
    core_mode = cm; wr_rand = wr;
    rd0 = rd_log.size(); wr0 = wr_log.size(); fr0 = frames;
    reg_wr(3'd2, src);
    reg_wr(3'd3, DST);
    reg_wr(3'd0, {30'd0, mode, 1'b1});
  endtask

  task automatic check_run(input logic [31:0] src, input bit mode);
    int bad;
    logic [31:0] d;
    chk("frames", frames - fr0, 1);
    chk("next_pulse", pulse_bad, 0);
    bad = 0;
    for (int k = 0; k < NPTS; k++)
      if (xs[k] != int'($signed(smem[src[13:2] + k][15:0]))) bad++;
    chk("fft_x_stream", bad, 0);
    chk("rd_count", rd_log.size() - rd0, NPTS);
    bad = 0;
    for (int k = 0; k < NPTS && rd0 + k < rd_log.size(); k++)
      if (rd_log[rd0 + k] != src + 32'(4 * k)) bad++;
    chk("rd_addr", bad, 0);
    chk("outstanding", max_inflight <= MAX_OUTST, 1'b1);
    chk("rd_wr_overlap", overlap, 0);
    chk("wr_count", wr_log.size() - wr0, NPTS);
    for (int k = 0; k < NPTS && wr0 + k < wr_log.size(); k++) begin
      chk("wr_addr", wr_log[wr0 + k].a, DST + 32'(4 * k));
      chk("wr_data", wr_log[wr0 + k].d, ref_word(mode, yre[k], yim[k]));
    end
    reg_rd(3'd1, d);
    chk("status_done", d, 32'h2);
    chk("irq_done", irq, 1'b1);
    reg_rd(3'd4, d);
    chk("cycles_min", d >= 32'(4 * NPTS) && d < 32'd5000, 1'b1);
    reg_wr(3'd1, 32'h6);
    chk("irq_clear", irq, 1'b0);
  endtask

  initial begin : main
    logic [31:0] d;
    int n;
    rst_n = 1'b0; slave_address = '0; slave_read = 1'b0; slave_write = 1'b0;
    slave_writedata = '0;
    repeat (3) @(negedge clk);
    chk("rst_mread", master_read, 1'b0);
    chk("rst_mwrite", master_write, 1'b0);
    chk("rst_maddr", master_address, 0);
    chk("rst_fft_next", fft_next, 1'b0);
    chk("rst_fft_reset", fft_reset, 1'b1);
    chk("rst_irq", irq, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    reg_rd(3'd1, d); chk("rst_status", d, 0);
    reg_rd(3'd4, d); chk("rst_cycles", d, 0);
    reg_rd(3'd7, d); chk("unmapped", d, 0);
    reg_wr(3'd2, 32'h1003);
    reg_rd(3'd2, d); chk("src_align", d, 32'h1000);

    fill_src(SRC_A, 1'b1);
    start_run(SRC_A, 1'b0, 0, 1'b0);
    wait_irq(2000);
    if (wr_log.size() > wr0) chk("impulse_bin0", wr_log[wr0].d, 32'd1);
    if (wr_log.size() >= wr0 + NPTS) chk("impulse_binN", wr_log[wr0 + NPTS - 1].d, 32'd1);
    check_run(SRC_A, 1'b0);

    for (int r = 0; r < 4; r++) begin
      fill_src(SRC_A, 1'b0);
      start_run(SRC_A, r[0], 0, 1'b1);
      wait_irq(3000);
      check_run(SRC_A, r[0]);
    end

    for (int m = 0; m < 2; m++) begin
      fill_src(SRC_A, 1'b0);
      start_run(SRC_A, m[0], 1, 1'b1);
      wait_irq(3000);
      if (wr_log.size() > wr0 + 3)
        chk("sat_word", wr_log[wr0 + 3].d, (m == 0) ? 32'h8000_0000 : 32'hFFFF_8000);
      check_run(SRC_A, m[0]);
    end

    start_run(SRC_A, 1'b0, 2, 1'b1);
    wait_irq(3000);
    reg_rd(3'd1, d); chk("timeout_status", d, 32'h4);
    chk("timeout_no_write", wr_log.size() - wr0, 0);
    chk("timeout_irq", irq, 1'b1);
    reg_wr(3'd1, 32'h6);
    chk("timeout_irq_clear", irq, 1'b0);
    reg_rd(3'd1, d); chk("timeout_status_clr", d, 0);

    fill_src(SRC_A, 1'b0);
    fill_src(SRC_B, 1'b0);
    start_run(SRC_A, 1'b0, 0, 1'b1);
    n = 0;
    while (!master_read && n < 200) begin @(negedge clk); n++; end
    chk("midrun_reading", master_read, 1'b1);
    reg_wr(3'd2, SRC_B);
    reg_wr(3'd0, 32'h3);
    wait_irq(3000);
    check_run(SRC_A, 1'b0);
    reg_rd(3'd2, d); chk("src_rewritten", d, SRC_B);

    fill_src(SRC_A, 1'b0);
    start_run(SRC_A, 1'b0, 0, 1'b1);
    n = 0;
    while (!master_write && n < 3000) begin @(negedge clk); n++; end
    chk("saw_write", master_write, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mwrite", master_write, 1'b0);
    chk("arst_mread", master_read, 1'b0);
    chk("arst_maddr", master_address, 0);
    chk("arst_fft_reset", fft_reset, 1'b1);
    chk("arst_fft_next", fft_next, 1'b0);
    chk("arst_irq", irq, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    reg_rd(3'd1, d); chk("arst_status", d, 0);
    fill_src(SRC_A, 1'b0);
    start_run(SRC_A, 1'b1, 0, 1'b1);
    wait_irq(3000);
    check_run(SRC_A, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
